cache_fill_fsm: RTL
===================

# cache_fill_fsm

Miss handler for the WISC instruction and data caches. On a cache miss it fetches the full 8-word block from the fixed-latency main memory, pipelining address issue against data return. It drives the data-array and tag-array write strobes and stalls the pipeline while the fill is in progress. It also emits the per-access `cache_req`/`cache_hit` strobes that feed the CPU stats/trace monitor (`icache_req`/`icache_hit`, `dcache_req`/`dcache_hit`). One instance sits beside each cache.

## Interface
- `ARCH_WIDTH`, 16, address/data width
- `WORDS_PER_BLOCK`, 8, 16-bit words per cache block (power of two)
- `MEM_LATENCY`, 4, cycles from `memory_req` to matching `memory_data_valid`; informational only, the FSM counts returns
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `access_req` in 1: cache lookup performed this cycle
- `miss_detected` in 1: lookup missed; held by the cache until fill completes
- `miss_address` in ARCH_WIDTH: byte address of the missing access
- `memory_data_valid` in 1: memory returns one word this cycle
- `fsm_busy` out 1: fill in progress (pipeline stall)
- `memory_req` out 1: read request valid this cycle
- `memory_address` out ARCH_WIDTH: word-aligned read address
- `write_data_array` out 1: write returned word into data array
- `fill_word_offset` out log2(WORDS_PER_BLOCK): word index of the current data-array write
- `write_tag_array` out 1: write tag and set valid, one pulse per fill
- `cache_req` out 1: stats strobe, one per architectural access
- `cache_hit` out 1: stats strobe, access hit on first lookup

## Operation
- States:
  - IDLE: lookup allowed.
  - FILL: issue and collect words.
  - DONE: one cycle, tag write.
- Reset values:
  - State IDLE; issue and receive counters 0; replay flag 0.
  - All outputs 0.
- IDLE → FILL when `miss_detected`=1.
  - Latch block base = `miss_address` with low log2(WORDS_PER_BLOCK)+1 bits cleared.
  - 8 words × 2 bytes = 16-byte block; base = `miss_address & 16'hFFF0`.
- FILL issue side:
  - `memory_req`=1 while issue count < WORDS_PER_BLOCK.
  - `memory_address` = base + 2·issue count.
  - Issue count increments every such cycle; memory never back-pressures.
- FILL receive side:
  - `write_data_array` = `memory_data_valid` (combinational, FILL only).
  - `fill_word_offset` = receive count.
  - Receive count increments on each valid.
- FILL → DONE on the valid that makes the receive count reach WORDS_PER_BLOCK.
- DONE → IDLE unconditionally. `write_tag_array`=1 only in DONE.
- `fsm_busy` = (state != IDLE), combinational from the state register.
- Stats strobes, combinational, IDLE only, suppressed when the replay flag is set:
  - `cache_req` = `access_req`.
  - `cache_hit` = `access_req` & ~`miss_detected`.
  - Replay flag sets on DONE → IDLE and clears after one IDLE cycle, so the post-fill re-lookup is not counted twice.
- Boundaries:
  - `memory_data_valid` in IDLE/DONE: ignored.
  - Valids beyond 8 in a fill: cannot occur, because the FSM leaves FILL.
  - `miss_detected` in FILL/DONE: ignored; no new base latched.
  - Base 0xFFF0: addresses 0xFFF0..0xFFFE, no wrap past 0xFFFE.
  - `rst` mid-fill: immediate return to IDLE, counters cleared, no tag write; partial data-array writes are left unvalidated.
- Counter widths: log2(WORDS_PER_BLOCK)+1 bits, so the terminal value 8 is representable.

## Timing
- Miss sampled at cycle 0 (IDLE, `cache_req`=1, `cache_hit`=0).
- Cycle 1: FILL, `fsm_busy`=1.
- Cycles 1–8: `memory_req`=1, addresses base+0 .. base+14.
- Cycles 5–12 (MEM_LATENCY=4): `write_data_array`=1, offsets 0..7.
- Cycle 13: DONE, `write_tag_array`=1, `fsm_busy`=1.
- Cycle 14: IDLE, `fsm_busy`=0, replay cycle with no stats.
- Total stall: 13 cycles.
- A hit in IDLE produces `cache_req`=`cache_hit`=1 in the same cycle, with zero added latency.

## Structure
- Shared package `wisc_cache_pkg` holds:
  - State enum (IDLE/FILL/DONE).
  - `WORDS_PER_BLOCK`.
  - `BLOCK_OFFSET_BITS`.
  - The base-align mask function.
- One sub-module, `cache_fill_counter`: saturating up-counter with enable and async-reset synchronous clear. It is instantiated twice, for issue and receive.

## Test plan
- Reset mid-fill: assert `rst` at cycle 7 of a fill → all outputs 0 immediately; no `write_tag_array`; a next miss restarts at offset 0.
- Single miss at `miss_address`=0x1236:
  - Addresses 0x1230..0x123E on cycles 1–8.
  - Offsets 0..7 on cycles 5–12.
  - `write_tag_array` on cycle 13 only; `fsm_busy` high for exactly 13 cycles.
- Hit stream: 10 cycles of `access_req`=1, `miss_detected`=0 → 10 `cache_req` and 10 `cache_hit`; `fsm_busy` stays 0.
- Miss then replay:
  - `access_req` held through the fill; hit on cycle 14 → exactly one `cache_req` and zero `cache_hit` for that access.
  - Next access on cycle 15 counts normally.
- Top of memory: `miss_address`=0xFFFF → addresses 0xFFF0..0xFFFE, no wrap, 8 data writes.
- Spurious inputs:
  - `memory_data_valid` pulses in IDLE → no `write_data_array`.
  - `miss_detected` toggling during FILL → base unchanged, single tag write.

Source files
------------

// File: rtl/wisc_cache_pkg.sv
// Shared types and constants for the WISC cache miss handler.
// Block geometry, FSM state encoding and base-address alignment.
package wisc_cache_pkg;

  localparam int ARCH_WIDTH        = 16;
  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W             = BLOCK_OFFSET_BITS + 1;
  localparam int MEM_LATENCY       = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } fill_state_e;

  // Word offset plus byte-in-word bit are cleared.
  function automatic logic [ARCH_WIDTH-1:0] block_base(
    input logic [ARCH_WIDTH-1:0] addr
  );
    logic [ARCH_WIDTH-1:0] mask;
    mask = ARCH_WIDTH'((1 << (BLOCK_OFFSET_BITS + 1)) - 1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/cache_fill_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Used for both the issue and the receive side of a block fill.
module cache_fill_counter
  import wisc_cache_pkg::*;
#(
  parameter int W   = CNT_W,
  parameter int MAX = WORDS_PER_BLOCK
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one block from fixed-latency memory,
// drives array write strobes, stalls the pipe, emits stats strobes.
module cache_fill_fsm
  import wisc_cache_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         access_req,
  input  logic                         miss_detected,
  input  logic [ARCH_WIDTH-1:0]        miss_address,
  input  logic                         memory_data_valid,
  output logic                         fsm_busy,
  output logic                         memory_req,
  output logic [ARCH_WIDTH-1:0]        memory_address,
  output logic                         write_data_array,
  output logic [BLOCK_OFFSET_BITS-1:0] fill_word_offset,
  output logic                         write_tag_array,
  output logic                         cache_req,
  output logic                         cache_hit
);

  fill_state_e           state_q, state_d;
  logic [ARCH_WIDTH-1:0] base_q, base_d;
  logic                  replay_q, replay_d;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      recv_cnt;
  logic                  cnt_clr;

  assign cnt_clr = (state_q == IDLE);

  cache_fill_counter #(
    .W   (CNT_W),
    .MAX (WORDS_PER_BLOCK)
  ) u_issue_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (memory_req),
    .cnt_o (issue_cnt)
  );

  cache_fill_counter #(
    .W   (CNT_W),
    .MAX (WORDS_PER_BLOCK)
  ) u_recv_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (cnt_clr),
    .en_i  (write_data_array),
    .cnt_o (recv_cnt)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    replay_d         = replay_q;
    memory_req       = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word_offset = '0;
    write_tag_array  = 1'b0;
    cache_req        = 1'b0;
    cache_hit        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The post-fill re-lookup was already counted as the miss.
        cache_req = access_req & ~replay_q;
        cache_hit = access_req & ~miss_detected & ~replay_q;
        replay_d  = 1'b0;
        if (miss_detected) begin
          state_d = FILL;
          base_d  = block_base(miss_address);
        end
      end
      FILL: begin
        memory_req       = issue_cnt < CNT_W'(WORDS_PER_BLOCK);
        memory_address   = base_q
                         + ARCH_WIDTH'({issue_cnt, 1'b0});
        write_data_array = memory_data_valid;
        fill_word_offset = recv_cnt[BLOCK_OFFSET_BITS-1:0];
        if (memory_data_valid
            && recv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        write_tag_array = 1'b1;
        replay_d        = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      replay_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      replay_q <= replay_d;
    end
  end

  assign fsm_busy = (state_q != IDLE);

endmodule
